// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - FP16 constants shared by the scale stage and the output packer
package fp16_pkg;

    localparam int FP16_W        = 16;
    localparam int FP16_SIGN_BIT = 15;

    localparam logic [FP16_W-1:0] FP16_ZERO    = 16'h0000;
    localparam logic [FP16_W-1:0] FP16_POS_INF = 16'h7C00;
    localparam logic [FP16_W-1:0] FP16_NEG_INF = 16'hFC00;

    typedef logic [FP16_W-1:0] fp16_t;

endpackage

// File: rtl/fp16_out_packer_if.sv
// rtl/fp16_out_packer_if.sv - element input stream and packed word output stream of fp16_out_packer
interface fp16_out_packer_if #(
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
);
    logic                  in_valid;
    logic                  in_ready;
    logic [15:0]           in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [16*LANES-1:0]   out_data;
    logic [LANES-1:0]      out_keep;
    logic                  out_last;
    logic [LVL_W-1:0]      fifo_level;

    // master: the environment feeding elements and draining words
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep, out_last, fifo_level
    );

    // slave: the packer itself
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep, out_last, fifo_level
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through FIFO, power-of-two depth, async active-low reset
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    // head is gated so a drained FIFO presents zeros rather than stale data
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/fp16_out_packer.sv
// rtl/fp16_out_packer.sv - packs serial FP16 results into LANES-wide words; FP16_OUT_RELU_EN zeroes negatives
module fp16_out_packer
    import fp16_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    fp16_out_packer_if.slave    bus
);
    localparam int LCW    = $clog2(LANES);
    localparam int WORD_W = FP16_W * LANES;
    localparam int ENT_W  = WORD_W + LANES + 1;

    logic [LCW-1:0]    lane_cnt;
    logic [WORD_W-1:0] pack_q;
    logic [WORD_W-1:0] word_c;
    logic [LANES-1:0]  keep_c;
    fp16_t             elem;
    logic              accept;
    logic              word_done;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ENT_W-1:0]  head;

`ifdef FP16_OUT_RELU_EN
    assign elem = bus.in_data[FP16_SIGN_BIT] ? FP16_ZERO : bus.in_data;
`else
    assign elem = bus.in_data;
`endif

    assign bus.in_ready = !fifo_full;
    assign accept       = bus.in_valid && bus.in_ready;
    assign word_done    = accept && ((lane_cnt == LCW'(LANES - 1)) || bus.in_last);

    // lanes above lane_cnt are still zero in pack_q, so a partial word needs no masking
    always_comb begin
        word_c = pack_q;
        keep_c = '0;
        for (int i = 0; i < LANES; i++) begin
            if (LCW'(i) == lane_cnt) begin
                word_c[i*FP16_W +: FP16_W] = elem;
            end
            keep_c[i] = (LCW'(i) <= lane_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt <= '0;
            pack_q   <= '0;
        end else if (accept) begin
            if (word_done) begin
                lane_cnt <= '0;
                pack_q   <= '0;
            end else begin
                lane_cnt <= lane_cnt + 1'b1;
                pack_q   <= word_c;
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (word_done),
        .push_data ({word_c, keep_c, bus.in_last}),
        .pop       (bus.out_valid && bus.out_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (bus.fifo_level)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = head[ENT_W-1 -: WORD_W];
    assign bus.out_keep  = head[LANES:1];
    assign bus.out_last  = head[0];
endmodule

// File: tb/tb_fp16_out_packer.sv
// tb/tb_fp16_out_packer.sv - directed-vector bench for fp16_out_packer
module tb_fp16_out_packer;
    localparam int LANES      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    fp16_out_packer_if #(.LANES(LANES), .FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) bus ();

    fp16_out_packer #(.LANES(LANES), .FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!bus.in_ready && t < 50) begin
            tick();
            t++;
        end
        if (!bus.in_ready) chk("send_timeout", 64'd0, 64'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic pop_word(input string tag, input logic [63:0] d, input logic [3:0] k, input logic l);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_data"},  bus.out_data, d);
        chk({tag, "_keep"},  64'(bus.out_keep), 64'(k));
        chk({tag, "_last"},  64'(bus.out_last), 64'(l));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] exp_w;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_level",     64'(bus.fifo_level), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
        chk("rst_out_keep",  64'(bus.out_keep), 64'd0);
        rst_n = 1'b1;
        tick();

        // full word, no backpressure
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b0);
        send(16'h4200, 1'b0);
        send(16'h4400, 1'b0);
        chk("full_level", 64'(bus.fifo_level), 64'd1);
        pop_word("full", 64'h4400_4200_4000_3C00, 4'hF, 1'b0);
        chk("drained_valid", 64'(bus.out_valid), 64'd0);
        chk("drained_data",  bus.out_data, 64'd0);

        // partial flush with a negative element
        send(16'h3C00, 1'b0);
        send(16'hBC00, 1'b1);
`ifdef FP16_OUT_RELU_EN
        pop_word("partial", 64'h0000_0000_0000_3C00, 4'h3, 1'b1);
`else
        pop_word("partial", 64'h0000_0000_BC00_3C00, 4'h3, 1'b1);
`endif

        // backpressure: 16 elements fill the FIFO
        for (int i = 1; i <= 16; i++) send(16'(i), 1'b0);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_level",    64'(bus.fifo_level), 64'd4);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd17;
        tick();
        bus.in_valid = 1'b0;
        chk("bp_blocked_level", 64'(bus.fifo_level), 64'd4);
        for (int w = 0; w < 4; w++) begin
            exp_w = {16'(4*w+4), 16'(4*w+3), 16'(4*w+2), 16'(4*w+1)};
            pop_word($sformatf("bp_w%0d", w), exp_w, 4'hF, 1'b0);
        end
        chk("bp_empty", 64'(bus.out_valid), 64'd0);
        for (int i = 17; i <= 20; i++) send(16'(i), 1'b0);
        pop_word("bp_w4", 64'h0014_0013_0012_0011, 4'hF, 1'b0);

        // concurrent push and pop at level 2
        for (int i = 0; i < 8; i++) send(16'h0100 + 16'(i), 1'b0);
        chk("cc_level_pre", 64'(bus.fifo_level), 64'd2);
        for (int i = 8; i < 11; i++) send(16'h0100 + 16'(i), 1'b0);
        bus.out_ready = 1'b1;
        send(16'h010B, 1'b0);
        bus.out_ready = 1'b0;
        chk("cc_level_post", 64'(bus.fifo_level), 64'd2);
        pop_word("cc_b", 64'h0107_0106_0105_0104, 4'hF, 1'b0);
        pop_word("cc_c", 64'h010B_010A_0109_0108, 4'hF, 1'b0);

        // asynchronous reset mid-packet with a word buffered
        for (int i = 0; i < 6; i++) send(16'h0200 + 16'(i), 1'b0);
        chk("rm_level_pre", 64'(bus.fifo_level), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rm_level",     64'(bus.fifo_level), 64'd0);
        chk("rm_out_data",  bus.out_data, 64'd0);
        chk("rm_in_ready",  64'(bus.in_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) send(16'h0A00 + 16'(i), 1'b0);
        pop_word("rm_clean", 64'h0A04_0A03_0A02_0A01, 4'hF, 1'b0);

        // in_last on the final lane, then in_last on lane 0
        send(16'h3400, 1'b0);
        send(16'h3500, 1'b0);
        send(16'h3600, 1'b0);
        send(16'h3700, 1'b1);
        pop_word("last_l3", 64'h3700_3600_3500_3400, 4'hF, 1'b1);
        send(16'h7C00, 1'b1);
        pop_word("last_l0", 64'h0000_0000_0000_7C00, 4'h1, 1'b1);
        chk("end_level", 64'(bus.fifo_level), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fp16_out_packer.md
Name: fp16_out_packer

Overview:
- Downstream neighbour of the per-column FP16 requantise/scale stage, which produces one FP16 result per cycle with fixed latency.
- Collects the serial FP16 stream into LANES-wide words, buffers them in a small FWFT FIFO and presents them to the writeback/SRAM port over a valid/ready handshake.
- Supports end-of-tile flush via in_last, with a partial-word keep mask.

Parameters:
- LANES, 4, FP16 elements per output word; power of two, 2..8.
- FIFO_DEPTH, 4, output words buffered; power of two, >=2.
- LVL_W, $clog2(FIFO_DEPTH+1), width of fifo_level.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_data valid; upstream aligns it to the scale stage's 3-cycle latency.
- in_ready  out  1  packer can accept this cycle.
- in_data  in  16  FP16 result.
- in_last  in  1  final element of tile; qualified by in_valid.
- out_valid  out  1  head word available.
- out_ready  in  1  sink accepts head word.
- out_data  out  16*LANES  packed word; lane 0 at bits [15:0].
- out_keep  out  LANES  per-lane valid mask.
- out_last  out  1  word closes a tile.
- fifo_level  out  LVL_W  words currently stored.

Behaviour:
- Accept = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = (fifo_level != FIFO_DEPTH). It is combinational from the registered count and does not look ahead at pop.
- Pack register and lane counter lane_cnt run 0..LANES-1.
  - On accept: in_data (ReLU-processed if enabled) is written to lane lane_cnt.
  - Word completes when lane_cnt == LANES-1 or in_last.
  - On completion the word is pushed in the same cycle, built combinationally from the pack register plus the current element. keep = bits 0..lane_cnt set. Lanes above lane_cnt are 0x0000. last = in_last.
  - After completion, lane_cnt -> 0 and the pack register clears to 0. Otherwise lane_cnt increments.
- A push can only occur when not full (implied by in_ready), so there is no overflow path.
- FIFO is FWFT: out_data/out_keep/out_last show the head entry and hold stable while out_valid && !out_ready.
- out_valid = (fifo_level != 0).
- Latency: the word is visible on out_valid the cycle after the accept that completes it.
- Simultaneous push and pop: level unchanged; both allowed at any non-full level.
- Push into an empty FIFO with out_ready=1: popped the following cycle. No same-cycle bypass.
- in_last on lane 0: single-lane word, keep=0b1.
- Read/write pointers wrap modulo FIFO_DEPTH.
- Reset (asynchronous, at any time including mid-packet or with the FIFO non-empty):
  - lane_cnt=0, pack register=0, pointers=0, fifo_level=0.
  - out_valid=0, out_data=0, out_keep=0, out_last=0.
  - in_ready=1 after release.
  - Partial words and buffered words are discarded.
- out_data/keep/last read 0 when empty; storage is reset to 0.

Optional Feature:
- Macro FP16_OUT_RELU_EN.
- Defined: an accepted element with sign bit 1 (any negative value, including -0 and -inf 0xFC00) is replaced by 0x0000 before packing. Positive values and +inf pass unchanged.
- Not defined: elements are packed bit-exact. No ReLU logic is instantiated.

Decomposition:
- Shared package fp16_pkg: FP16_W=16, FP16_ZERO=16'h0000, FP16_POS_INF=16'h7C00, FP16_NEG_INF=16'hFC00, and a sign-bit index constant. The scale stage reuses it.
- One sub-module: sync_fifo_fwft, parameterised width/depth, async active-low reset, with push/pop/full/empty/level.
- Packing logic and ReLU stay in fp16_out_packer.

Test Plan:
- No backpressure: accept 0x3C00, 0x4000, 0x4200, 0x4400 -> next cycle out_valid=1, out_data=0x4400_4200_4000_3C00, keep=0xF, last=0.
- Partial flush, RELU off: accept 0x3C00, then 0xBC00 with in_last -> out_data=0x0000_0000_BC00_3C00, keep=0x3, last=1. Same stimulus with FP16_OUT_RELU_EN -> out_data=0x0000_0000_0000_3C00.
- Backpressure: out_ready=0, offer 20 elements 0x0001..0x0014 -> in_ready falls after the 16th accept, fifo_level=4. Raise out_ready -> four words pop in order, then elements 17..20 pack into a fifth word, with no loss or duplication.
- Concurrent push/pop: at fifo_level=2, complete a word while out_ready=1 -> fifo_level stays 2 and word order is preserved.
- Reset mid-packet: accept 2 elements and hold 1 word buffered, then pulse rst_n low -> out_valid=0, fifo_level=0, out_data=0. The next 4 elements produce a clean keep=0xF word.
- in_last on lane LANES-1 (4th element) -> keep=0xF, last=1, lane_cnt back to 0. The next single element with in_last -> keep=0x1.
